alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 134 +++++++++++++
 tb/tb_alu_dispatch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - four-bank ALU request dispatcher with per-bank FIFOs and issue/wait FSMs
module alu_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_bank,
    input  logic [1:0]   req_command,
    input  logic [31:0]  req_data1,
    input  logic [31:0]  req_data2,
    output logic [7:0]   alu_command,
    output logic [127:0] alu_data1,
    output logic [127:0] alu_data2,
    input  logic [7:0]   alu_response,
    output logic [3:0]   bank_busy,
    output logic [11:0]  fifo_count,
    output logic [3:0]   timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int EW = 66;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [3:0] full;
    logic       push;

    assign req_ready = !full[req_bank];
    // NOP requests are accepted (handshake completes) but never stored
    assign push = req_valid && req_ready && (req_command != 2'b00);

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [EW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0] count_q, count_d;
        logic [1:0]    state_q, state_d;
        logic [1:0]    cmd_q, cmd_d;
        logic [TW-1:0] timer_q, timer_d;
        logic          err_q, err_d;
        logic [31:0]   d1_q, d1_d, d2_q, d2_d;
        logic          bank_push, pop;

        assign bank_push = push && (req_bank == 2'(b));

        always_ff @(posedge clock) begin
            if (bank_push) begin
                mem[wr_q] <= {req_command, req_data1, req_data2};
            end
        end

        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            err_d   = err_q;
            cmd_d   = cmd_q;
            d1_d    = d1_q;
            d2_d    = d2_q;
            pop     = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        pop                 = 1'b1;
                        {cmd_d, d1_d, d2_d} = mem[rd_q];
                        state_d             = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
                ST_WAIT: begin
                    // a response in the final timer cycle takes priority over the timeout
                    if (alu_response[2*b +: 2] != 2'b00) begin
                        state_d = ST_IDLE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            wr_d = bank_push ? wr_q + PW'(1) : wr_q;
            rd_d = pop ? rd_q + PW'(1) : rd_q;
            case ({bank_push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
                state_q <= ST_IDLE;
                timer_q <= '0;
                err_q   <= 1'b0;
                cmd_q   <= 2'b00;
                d1_q    <= '0;
                d2_q    <= '0;
            end else begin
                wr_q    <= wr_d;
                rd_q    <= rd_d;
                count_q <= count_d;
                state_q <= state_d;
                timer_q <= timer_d;
                err_q   <= err_d;
                cmd_q   <= cmd_d;
                d1_q    <= d1_d;
                d2_q    <= d2_d;
            end
        end

        assign full[b]                 = (count_q == CW'(DEPTH));
        assign alu_command[2*b +: 2]   = (state_q == ST_ISSUE) ? cmd_q : 2'b00;
        assign alu_data1[32*b +: 32]   = d1_q;
        assign alu_data2[32*b +: 32]   = d2_q;
        assign bank_busy[b]            = (state_q != ST_IDLE);
        assign fifo_count[3*b +: 3]    = 3'(count_q);
        assign timeout_err[b]          = err_q;
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed and table-driven checks for alu_dispatch
module tb_alu_dispatch;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_bank;
    logic [1:0]   req_command;
    logic [31:0]  req_data1;
    logic [31:0]  req_data2;
    logic [7:0]   alu_command;
    logic [127:0] alu_data1;
    logic [127:0] alu_data2;
    logic [7:0]   alu_response;
    logic [3:0]   bank_busy;
    logic [11:0]  fifo_count;
    logic [3:0]   timeout_err;

    alu_dispatch #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bank     (req_bank),
        .req_command  (req_command),
        .req_data1    (req_data1),
        .req_data2    (req_data2),
        .alu_command  (alu_command),
        .alu_data1    (alu_data1),
        .alu_data2    (alu_data2),
        .alu_response (alu_response),
        .bank_busy    (bank_busy),
        .fifo_count   (fifo_count),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          bank;
        logic [1:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [11:0] exp_cnt;
        logic [7:0]  exp_alu;
        logic [3:0]  exp_busy;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
    } vec_t;

    vec_t vecs [5];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int bank, input logic [1:0] cmd, input logic [31:0] d1, input logic [31:0] d2);
        req_valid   = 1'b1;
        req_bank    = 2'(bank);
        req_command = cmd;
        req_data1   = d1;
        req_data2   = d2;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    logic [33:0] sb [4][8];
    int          wr_i [4];
    int          rd_i [4];
    int          lat [4];
    int          sent;
    int          issued;
    logic [7:0]  resp;
    logic [1:0]  bp_cmd [5];
    logic [11:0] bp_cnt [5];

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_bank     = 2'd0;
        req_command  = 2'b00;
        req_data1    = '0;
        req_data2    = '0;
        alu_response = '0;

        vecs[0] = '{2, 2'b01, 32'h1,        32'h2,        12'h040, 8'h10, 4'b0100, 32'h1,        32'h2};
        vecs[1] = '{0, 2'b11, 32'hDEADBEEF, 32'h12345678, 12'h001, 8'h03, 4'b0001, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{3, 2'b10, 32'hFFFFFFFF, 32'h0,        12'h200, 8'h80, 4'b1000, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{1, 2'b01, 32'hA5A5A5A5, 32'h5A5A5A5A, 12'h008, 8'h04, 4'b0010, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[4] = '{1, 2'b00, 32'h11111111, 32'h22222222, 12'h000, 8'h00, 4'b0000, 32'hA5A5A5A5, 32'h5A5A5A5A};

        #3;
        check("rst_alu_command", alu_command, 8'h00);
        check("rst_alu_data1", alu_data1, 128'h0);
        check("rst_alu_data2", alu_data2, 128'h0);
        check("rst_bank_busy", bank_busy, 4'h0);
        check("rst_fifo_count", fifo_count, 12'h000);
        check("rst_timeout_err", timeout_err, 4'h0);
        @(posedge clock);
        step();
        reset = 1'b0;

        // single requests into idle banks
        for (int i = 0; i < 5; i++) begin
            drive_req(vecs[i].bank, vecs[i].cmd, vecs[i].d1, vecs[i].d2);
            #1;
            check("vec_ready", req_ready, 1'b1);
            step();
            req_valid = 1'b0;
            check("vec_count_after_accept", fifo_count, vecs[i].exp_cnt);
            check("vec_no_early_issue", alu_command, 8'h00);
            step();
            check("vec_issue_cmd", alu_command, vecs[i].exp_alu);
            check("vec_issue_d1", alu_data1[32*vecs[i].bank +: 32], vecs[i].exp_d1);
            check("vec_issue_d2", alu_data2[32*vecs[i].bank +: 32], vecs[i].exp_d2);
            check("vec_count_after_pop", fifo_count, 12'h000);
            step();
            check("vec_cmd_one_cycle", alu_command, 8'h00);
            check("vec_busy_wait", bank_busy, vecs[i].exp_busy);
            alu_response = '0;
            alu_response[2*vecs[i].bank +: 2] = 2'b01;
            step();
            alu_response = '0;
            check("vec_busy_done", bank_busy, 4'h0);
        end

        // back-pressure on bank 0 with no responses
        bp_cmd = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        bp_cnt = '{12'h001, 12'h001, 12'h002, 12'h003, 12'h004};
        for (int i = 0; i < 5; i++) begin
            drive_req(0, bp_cmd[i], 32'h100 + i, 32'h200 + i);
            #1;
            check("bp_ready", req_ready, 1'b1);
            step();
            check("bp_count", fifo_count, bp_cnt[i]);
        end
        req_bank = 2'd0;
        #1;
        check("bp_full_not_ready", req_ready, 1'b0);
        check("bp_busy", bank_busy, 4'b0001);
        req_bank = 2'd1;
        #1;
        check("bp_other_bank_ready", req_ready, 1'b1);
        req_bank = 2'd0;
        step();
        req_valid = 1'b0;
        check("bp_full_no_push", fifo_count, 12'h004);
        #2 reset = 1'b1;
        #1;
        check("bp_reset_count", fifo_count, 12'h000);
        reset = 1'b0;

        // response arriving in the last timer cycle wins over the timeout
        step();
        drive_req(2, 2'b11, 32'h77, 32'h88);
        step();
        req_valid = 1'b0;
        repeat (17) @(posedge clock);
        #1;
        check("race_still_waiting", bank_busy, 4'b0100);
        alu_response[5:4] = 2'b01;
        step();
        alu_response = '0;
        check("race_no_err", timeout_err, 4'h0);
        check("race_idle", bank_busy, 4'h0);

        // timeout on bank 3 with a second entry queued
        drive_req(3, 2'b10, 32'h33, 32'h0);
        step();
        drive_req(3, 2'b01, 32'h44, 32'h0);
        step();
        req_valid = 1'b0;
        repeat (16) @(posedge clock);
        #1;
        check("to_before_err", timeout_err, 4'h0);
        check("to_before_busy", bank_busy, 4'b1000);
        step();
        check("to_err_set", timeout_err, 4'b1000);
        check("to_idle", bank_busy, 4'h0);
        check("to_queued", fifo_count, 12'h200);
        step();
        check("to_next_issue", alu_command, 8'h40);
        check("to_next_d1", alu_data1[127:96], 32'h44);
        step();
        alu_response[7:6] = 2'b01;
        step();
        alu_response = '0;
        check("to_sticky", timeout_err, 4'b1000);
        check("to_done", bank_busy, 4'h0);

        // reset while bank 1 waits with two entries queued
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 2'b11, 32'h500 + i, 32'h600 + i);
            step();
        end
        req_valid = 1'b0;
        check("rw_pre_count", fifo_count, 12'h010);
        check("rw_pre_busy", bank_busy, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check("rw_count", fifo_count, 12'h000);
        check("rw_busy", bank_busy, 4'h0);
        check("rw_cmd", alu_command, 8'h00);
        check("rw_data1", alu_data1, 128'h0);
        check("rw_err_cleared", timeout_err, 4'h0);
        #1 reset = 1'b0;
        alu_response[3:2] = 2'b01;
        repeat (3) step();
        alu_response = '0;
        check("rw_late_resp_busy", bank_busy, 4'h0);
        check("rw_late_resp_cmd", alu_command, 8'h00);
        check("rw_late_resp_count", fifo_count, 12'h000);

        // interleaved traffic to all banks with random response latency
        for (int b = 0; b < 4; b++) begin
            wr_i[b] = 0;
            rd_i[b] = 0;
            lat[b]  = 0;
        end
        sent   = 0;
        issued = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            step();
            resp = '0;
            for (int b = 0; b < 4; b++) begin
                if (lat[b] > 0) begin
                    lat[b]--;
                    if (lat[b] == 0) resp[2*b +: 2] = 2'b01;
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (alu_command[2*b +: 2] != 2'b00) begin
                    issued++;
                    if (rd_i[b] == wr_i[b]) begin
                        n_total++;
                        $display("FAIL conc_dup bank %0d: got issue %0h expected none", b, alu_command[2*b +: 2]);
                    end else begin
                        check("conc_issue", {alu_command[2*b +: 2], alu_data1[32*b +: 32]}, sb[b][rd_i[b] % 8]);
                        rd_i[b]++;
                    end
                    lat[b] = $urandom_range(3, 5);
                end
            end
            alu_response = resp;
            if (sent < 12) begin
                drive_req(sent % 4, 2'((sent % 3) + 1), 32'hC0000000 + sent, 32'hD0000000 + sent);
                #1;
                if (req_ready) begin
                    sb[sent % 4][wr_i[sent % 4] % 8] = {2'((sent % 3) + 1), 32'hC0000000 + sent};
                    wr_i[sent % 4]++;
                    sent++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        alu_response = '0;
        check("conc_sent", sent, 12);
        check("conc_issued", issued, 12);
        for (int b = 0; b < 4; b++) begin
            check("conc_drained", rd_i[b], wr_i[b]);
        end
        check("conc_no_err", timeout_err, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
